fc_rx_word_sync: RTL and testbench
==================================

Name: fc_rx_word_sync

Overview:
- Sits directly downstream of the fc_8g_xcvr PHY RX parallel interface, in the PHY recovered-clock domain. Consumes 32-bit words with per-byte K, error and disparity flags.
- Implements the FC-FS transmission-word synchronisation state machine and classifies primitive signals (IDLE, R_RDY, SOFx, EOFx).
- Forwards words with a word-sync flag to the FC link/framing logic and exposes saturating error counters for the management CSR block.

Parameters:
- ACQ_OS, 3, consecutive valid ordered sets required to acquire sync.
- LOS_ERRS, 4, invalid-word credit count that forces loss of sync.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  PHY RX recovered clock.
- reset  in  1  synchronous, active-high.
- rx_data  in  32  PHY parallel data; byte 0 = [7:0], transmitted first.
- rx_datak  in  4  per-byte K flag.
- rx_errdetect  in  4  per-byte 8b10b code-violation flag.
- rx_disperr  in  4  per-byte running-disparity error flag.
- rx_ready  in  1  PHY RX ready AND rx_syncstatus (byte-aligned).
- clear_cnt  in  1  single-cycle pulse; zeroes both counters.
- out_data  out  32  registered copy of rx_data.
- out_datak  out  4  registered copy of rx_datak.
- out_valid  out  1  word is valid and the link is in SYNC.
- word_sync  out  1  FSM state is SYNC.
- prim  out  4  primitive code of the current word, fc_prim_t.
- invalid_cnt  out  CNT_W  saturating count of invalid transmission words.
- los_cnt  out  CNT_W  saturating count of SYNC to LOSS transitions.

Behaviour:
- **Reset:** all outputs are 0 and the FSM is in LOSS; prim = PRIM_NONE.
- **Latency:** exactly 1 cycle from rx_* to all out_*. prim, word_sync and out_valid refer to the same word as out_data.
- **Invalid word:** any rx_errdetect or rx_disperr bit set, OR K in bytes 1-3, OR rx_datak[0] set with byte 0 != 0xBC.
- **Ordered set:** rx_datak = 4'b0001, byte 0 = 0xBC (K28.5), and the word is not invalid.
- **rx_ready = 0:** the word is ignored for counting. The FSM is forced to LOSS. If the previous state was SYNC, los_cnt increments.
- **LOSS state:**
  - Count consecutive ordered sets (acq_cnt).
  - Any non-OS word, including a valid data word, resets acq_cnt to 0.
  - acq_cnt reaching ACQ_OS moves the FSM to SYNC on that same word. That word's output therefore has word_sync = 1.
- **SYNC state:**
  - err_cnt runs 0..LOS_ERRS.
  - An invalid word increments err_cnt and clears good_run.
  - A valid word increments good_run. When good_run reaches 2 and err_cnt > 0, err_cnt decrements and good_run clears.
  - err_cnt reaching LOS_ERRS moves the FSM to LOSS, clears acq_cnt and increments los_cnt.
  - An invalid word and a decrement never occur in the same cycle; invalid takes priority.
- **invalid_cnt:** increments on every invalid word while rx_ready = 1, in any state.
- **Counters:** saturate at all-ones. clear_cnt takes priority over a same-cycle increment; the result is 0.
- **out_valid:** equals word_sync AND the word is not invalid.
- **prim decode:** applies to ordered sets only; otherwise PRIM_NONE. Codes:
  - IDLE = BC 95 B5 B5
  - R_RDY = BC 95 4A 4A
  - SOFi3 = BC B5 56 56
  - SOFn3 = BC B5 36 36
  - EOFn = BC 95 D5 D5 or BC 8A D5 D5
  - EOFt = BC 95 75 75 or BC 8A 75 75
  - any other OS = PRIM_OTHER
- **Reset mid-operation:** returns to LOSS within the same cycle boundary. Counters clear on reset.

Decomposition:
- **Package fc_pkg:**
  - fc_prim_t enum: PRIM_NONE, PRIM_IDLE, PRIM_R_RDY, PRIM_SOFI3, PRIM_SOFN3, PRIM_EOFN, PRIM_EOFT, PRIM_OTHER.
  - Constant K28_5 = 8'hBC.
  - Byte constants for the ordered-set words listed above.
  - fc_sync_state_t enum: LOSS, SYNC.
- **Sub-module fc_prim_decode:** purely combinational word-to-fc_prim_t classifier, reusable on the TX side.

Test Plan:
- **Reset release:** apply reset, then 3 IDLE words (BC95B5B5, datak 0001) with rx_ready = 1 → word_sync goes high on the 3rd word's output, i.e. cycle 3 after the first word; prim = PRIM_IDLE.
- **Broken acquisition:** IDLE, IDLE, data 0x12345678, IDLE, IDLE → word_sync stays 0; a 3rd following IDLE → word_sync = 1.
- **Loss of sync:** in SYNC, inject 4 words with rx_disperr = 4'b0010, each separated by one valid word → word_sync drops after the 4th; los_cnt = 1; invalid_cnt = 4.
- **Error-credit recovery:** in SYNC, pattern invalid, valid, valid repeated 10 times → word_sync stays 1; invalid_cnt = 10.
- **Primitive decode:** in SYNC, send BC954A4A, BCB55656, BC95D5D5 and a data word → prim = R_RDY, SOFI3, EOFN, NONE; out_valid = 1 on all four.
- **Counter saturation and clear:** preload invalid_cnt to 0xFFFF, then inject 2 more invalid words → counter holds at 0xFFFF; clear_cnt asserted with a same-cycle invalid word → invalid_cnt = 0.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared Fibre Channel RX types: primitive codes, sync states and
// ordered-set words (byte 0 in bits [7:0], transmitted first).
package fc_pkg;

  typedef enum logic [3:0] {
    PRIM_NONE,
    PRIM_IDLE,
    PRIM_R_RDY,
    PRIM_SOFI3,
    PRIM_SOFN3,
    PRIM_EOFN,
    PRIM_EOFT,
    PRIM_OTHER
  } fc_prim_t;

  typedef enum logic {
    LOSS,
    SYNC
  } fc_sync_state_t;

  localparam logic [7:0] K28_5 = 8'hBC;

  localparam logic [31:0] OS_IDLE   = 32'hB5B5_95BC;
  localparam logic [31:0] OS_R_RDY  = 32'h4A4A_95BC;
  localparam logic [31:0] OS_SOFI3  = 32'h5656_B5BC;
  localparam logic [31:0] OS_SOFN3  = 32'h3636_B5BC;
  localparam logic [31:0] OS_EOFN_P = 32'hD5D5_95BC;
  localparam logic [31:0] OS_EOFN_N = 32'hD5D5_8ABC;
  localparam logic [31:0] OS_EOFT_P = 32'h7575_95BC;
  localparam logic [31:0] OS_EOFT_N = 32'h7575_8ABC;

  // Code violation, disparity error or a misplaced/wrong K character.
  function automatic logic word_invalid(
    input logic [31:0] data,
    input logic [3:0]  datak,
    input logic [3:0]  errdetect,
    input logic [3:0]  disperr
  );
    return (|errdetect) || (|disperr) ||
           (|datak[3:1]) ||
           (datak[0] && (data[7:0] != K28_5));
  endfunction

endpackage

// File: rtl/fc_prim_decode.sv
// Combinational classifier of a 32-bit transmission word into
// an fc_prim_t code; usable on both RX and TX paths.
module fc_prim_decode
  import fc_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [3:0]  datak_i,
  input  logic        err_i,
  output fc_prim_t    prim_o
);

  logic is_os;

  assign is_os = (datak_i == 4'b0001) &&
                 (data_i[7:0] == K28_5) &&
                 !err_i;

  always_comb begin
    prim_o = PRIM_NONE;
    if (is_os) begin
      unique case (data_i)
        OS_IDLE:   prim_o = PRIM_IDLE;
        OS_R_RDY:  prim_o = PRIM_R_RDY;
        OS_SOFI3:  prim_o = PRIM_SOFI3;
        OS_SOFN3:  prim_o = PRIM_SOFN3;
        OS_EOFN_P,
        OS_EOFN_N: prim_o = PRIM_EOFN;
        OS_EOFT_P,
        OS_EOFT_N: prim_o = PRIM_EOFT;
        default:   prim_o = PRIM_OTHER;
      endcase
    end
  end

endmodule

// File: rtl/fc_rx_word_sync.sv
// FC transmission-word synchronisation, primitive classification
// and saturating error statistics on the PHY RX word stream.
module fc_rx_word_sync
  import fc_pkg::*;
#(
  parameter int ACQ_OS   = 3,
  parameter int LOS_ERRS = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      rx_data,
  input  logic [3:0]       rx_datak,
  input  logic [3:0]       rx_errdetect,
  input  logic [3:0]       rx_disperr,
  input  logic             rx_ready,
  input  logic             clear_cnt,
  output logic [31:0]      out_data,
  output logic [3:0]       out_datak,
  output logic             out_valid,
  output logic             word_sync,
  output fc_prim_t         prim,
  output logic [CNT_W-1:0] invalid_cnt,
  output logic [CNT_W-1:0] los_cnt
);

  localparam int AW = $clog2(ACQ_OS + 1);
  localparam int EW = $clog2(LOS_ERRS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fc_sync_state_t state_q, state_d;
  logic [AW-1:0]  acq_q, acq_d;
  logic [EW-1:0]  err_q, err_d;
  logic [1:0]     good_q, good_d;
  logic           los_ev;

  logic           inv;
  logic           os;
  fc_prim_t       prim_d;
  logic           valid_d;
  logic           sync_d;

  logic [CNT_W-1:0] inv_cnt_q, inv_cnt_d;
  logic [CNT_W-1:0] los_cnt_q, los_cnt_d;
  logic [31:0]      data_q;
  logic [3:0]       datak_q;
  logic             valid_q;
  logic             sync_q;
  fc_prim_t         prim_q;

  assign inv = word_invalid(rx_data, rx_datak,
                            rx_errdetect, rx_disperr);
  assign os  = (rx_datak == 4'b0001) && !inv;

  fc_prim_decode u_dec (
    .data_i  (rx_data),
    .datak_i (rx_datak),
    .err_i   (inv),
    .prim_o  (prim_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOSS;
      acq_q   <= '0;
      err_q   <= '0;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      acq_q   <= acq_d;
      err_q   <= err_d;
      good_q  <= good_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acq_d   = acq_q;
    err_d   = err_q;
    good_d  = good_q;
    los_ev  = 1'b0;
    if (!rx_ready) begin
      state_d = LOSS;
      acq_d   = '0;
      err_d   = '0;
      good_d  = '0;
      los_ev  = (state_q == SYNC);
    end else begin
      unique case (state_q)
        LOSS: begin
          if (!os) begin
            acq_d = '0;
          end else if (acq_q == AW'(ACQ_OS - 1)) begin
            state_d = SYNC;
            acq_d   = '0;
            err_d   = '0;
            good_d  = '0;
          end else begin
            acq_d = acq_q + 1'b1;
          end
        end
        SYNC: begin
          if (inv) begin
            good_d = '0;
            if (err_q == EW'(LOS_ERRS - 1)) begin
              state_d = LOSS;
              acq_d   = '0;
              err_d   = '0;
              los_ev  = 1'b1;
            end else begin
              err_d = err_q + 1'b1;
            end
          end else if (good_q == 2'd1 && err_q != '0) begin
            // Two good words in a row buy back one error credit.
            err_d  = err_q - 1'b1;
            good_d = '0;
          end else if (good_q != 2'd2) begin
            good_d = good_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    sync_d  = (state_d == SYNC);
    valid_d = sync_d && !inv;
  end

  always_comb begin
    inv_cnt_d = inv_cnt_q;
    los_cnt_d = los_cnt_q;
    if (clear_cnt) begin
      inv_cnt_d = '0;
      los_cnt_d = '0;
    end else begin
      if (rx_ready && inv && inv_cnt_q != CNT_MAX)
        inv_cnt_d = inv_cnt_q + 1'b1;
      if (los_ev && los_cnt_q != CNT_MAX)
        los_cnt_d = los_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      datak_q   <= '0;
      valid_q   <= 1'b0;
      sync_q    <= 1'b0;
      prim_q    <= PRIM_NONE;
      inv_cnt_q <= '0;
      los_cnt_q <= '0;
    end else begin
      data_q    <= rx_data;
      datak_q   <= rx_datak;
      valid_q   <= valid_d;
      sync_q    <= sync_d;
      prim_q    <= prim_d;
      inv_cnt_q <= inv_cnt_d;
      los_cnt_q <= los_cnt_d;
    end
  end

  assign out_data    = data_q;
  assign out_datak   = datak_q;
  assign out_valid   = valid_q;
  assign word_sync   = sync_q;
  assign prim        = prim_q;
  assign invalid_cnt = inv_cnt_q;
  assign los_cnt     = los_cnt_q;

endmodule

// File: tb/tb_fc_rx_word_sync.sv
// Scoreboard bench for fc_rx_word_sync: directed scenarios plus
// random word streams checked against a behavioural model.
module tb_fc_rx_word_sync;

  localparam int ACQ = 3;
  localparam int LOS = 4;
  localparam int MAXC = 65535;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rx_data = '0;
  logic [3:0]  rx_datak = '0;
  logic [3:0]  rx_errdetect = '0;
  logic [3:0]  rx_disperr = '0;
  logic        rx_ready = 1'b0;
  logic        clear_cnt = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_datak;
  logic        out_valid;
  logic        word_sync;
  logic [3:0]  prim;
  logic [15:0] invalid_cnt;
  logic [15:0] los_cnt;

  fc_rx_word_sync #(
    .ACQ_OS   (ACQ),
    .LOS_ERRS (LOS),
    .CNT_W    (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_datak     (rx_datak),
    .rx_errdetect (rx_errdetect),
    .rx_disperr   (rx_disperr),
    .rx_ready     (rx_ready),
    .clear_cnt    (clear_cnt),
    .out_data     (out_data),
    .out_datak    (out_datak),
    .out_valid    (out_valid),
    .word_sync    (word_sync),
    .prim         (prim),
    .invalid_cnt  (invalid_cnt),
    .los_cnt      (los_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        v;
    logic        s;
    logic [3:0]  p;
    logic [15:0] ic;
    logic [15:0] lc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  bit m_sync;
  int m_acq, m_cred, m_good, m_inv, m_los;

  // Primitive lookup by transmission-order bytes (b0 first).
  function automatic int prim_of(input logic [7:0] b1,
                                 input logic [7:0] b2,
                                 input logic [7:0] b3);
    if (b2 != b3) return 7;
    if (b1 == 8'h95 && b2 == 8'hB5) return 1;
    if (b1 == 8'h95 && b2 == 8'h4A) return 2;
    if (b1 == 8'hB5 && b2 == 8'h56) return 3;
    if (b1 == 8'hB5 && b2 == 8'h36) return 4;
    if ((b1 == 8'h95 || b1 == 8'h8A) && b2 == 8'hD5) return 5;
    if ((b1 == 8'h95 || b1 == 8'h8A) && b2 == 8'h75) return 6;
    return 7;
  endfunction

  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    reset = 1'b1;
    clear_cnt = 1'b0;
    m_sync = 0; m_acq = 0; m_cred = 0; m_good = 0;
    m_inv = 0; m_los = 0;
    e.d = '0; e.k = '0; e.v = 0; e.s = 0; e.p = '0;
    e.ic = '0; e.lc = '0;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k,
                      input logic [3:0] er, input logic [3:0] dp,
                      input bit rdy, input bit clr);
    exp_t e;
    bit inv, os;
    @(negedge clk);
    reset = 1'b0;
    rx_data = d; rx_datak = k; rx_errdetect = er;
    rx_disperr = dp; rx_ready = rdy; clear_cnt = clr;
    inv = (er != 0) || (dp != 0) || (k[3:1] != 0) ||
          (k[0] && d[7:0] != 8'hBC);
    os = (k == 4'b0001) && !inv;
    if (!rdy) begin
      if (m_sync) m_los++;
      m_sync = 0; m_acq = 0; m_cred = 0; m_good = 0;
    end else if (!m_sync) begin
      if (os) begin
        m_acq++;
        if (m_acq == ACQ) begin
          m_sync = 1; m_acq = 0; m_cred = 0; m_good = 0;
        end
      end else m_acq = 0;
    end else if (inv) begin
      m_cred++;
      m_good = 0;
      if (m_cred == LOS) begin
        m_sync = 0; m_acq = 0; m_cred = 0;
        m_los++;
      end
    end else begin
      m_good++;
      if (m_good >= 2 && m_cred > 0) begin
        m_cred--;
        m_good = 0;
      end
    end
    if (rdy && inv) m_inv++;
    if (m_inv > MAXC) m_inv = MAXC;
    if (m_los > MAXC) m_los = MAXC;
    if (clr) begin m_inv = 0; m_los = 0; end
    e.d = d; e.k = k; e.s = m_sync; e.v = m_sync && !inv;
    e.p = os ? 4'(prim_of(d[15:8], d[23:16], d[31:24])) : 4'd0;
    e.ic = 16'(m_inv); e.lc = 16'(m_los);
    exp_q.push_back(e);
  endtask

  task automatic os_word(input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3);
    send({b3, b2, b1, 8'hBC}, 4'b0001, 4'h0, 4'h0, 1, 0);
  endtask

  task automatic idle();
    os_word(8'h95, 8'hB5, 8'hB5);
  endtask

  task automatic dword(input logic [31:0] d);
    send(d, 4'b0000, 4'h0, 4'h0, 1, 0);
  endtask

  task automatic bad(input bit clr);
    send(32'hCAFE_0001, 4'b0000, 4'h0, 4'b0010, 1, clr);
  endtask

  task automatic rand_word();
    logic [31:0] d;
    logic [3:0]  k, er, dp;
    int sel;
    bit rdy, clr;
    d = $urandom; k = 4'b0001; er = 0; dp = 0;
    sel = $urandom_range(0, 15);
    rdy = ($urandom_range(0, 63) != 0);
    clr = ($urandom_range(0, 127) == 0);
    case (sel)
      6:  d = 32'h4A4A_95BC;
      7:  d = 32'h5656_B5BC;
      8:  d = 32'h3636_B5BC;
      9:  d = $urandom_range(0, 1) ? 32'hD5D5_95BC : 32'hD5D5_8ABC;
      10: d = $urandom_range(0, 1) ? 32'h7575_95BC : 32'h7575_8ABC;
      11: d[7:0] = 8'hBC;
      12: k = 4'b0000;
      13: begin k = 4'(sel & 1); d = 32'hB5B5_95BC;
                dp = 4'($urandom_range(1, 15)); end
      14: begin k = 4'b0000; er = 4'($urandom_range(1, 15)); end
      15: begin
        if ($urandom_range(0, 1) != 0) k = 4'($urandom_range(2, 15));
        else d[7:0] = 8'h3C;
      end
      default: d = 32'hB5B5_95BC;
    endcase
    send(d, k, er, dp, rdy, clr);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (out_data !== e.d || out_datak !== e.k ||
          out_valid !== e.v || word_sync !== e.s ||
          prim !== e.p || invalid_cnt !== e.ic ||
          los_cnt !== e.lc) begin
        n_err++;
        $display("FAIL vec%0d got d=%h k=%h v=%b s=%b p=%0d ic=%0d lc=%0d want d=%h k=%h v=%b s=%b p=%0d ic=%0d lc=%0d",
                 n_vec, out_data, out_datak, out_valid, word_sync,
                 prim, invalid_cnt, los_cnt, e.d, e.k, e.v, e.s,
                 e.p, e.ic, e.lc);
      end
    end
  end

  initial begin
    do_reset();
    do_reset();
    // acquisition from reset
    repeat (3) idle();
    // broken acquisition
    do_reset();
    idle(); idle(); dword(32'h1234_5678);
    idle(); idle(); idle();
    // loss of sync
    for (int i = 0; i < 4; i++) begin
      bad(0);
      if (i < 3) idle();
    end
    repeat (3) idle();
    // error-credit recovery
    for (int i = 0; i < 10; i++) begin
      bad(0); idle(); dword($urandom);
    end
    // primitive decode
    os_word(8'h95, 8'h4A, 8'h4A);
    os_word(8'hB5, 8'h56, 8'h56);
    os_word(8'h95, 8'hD5, 8'hD5);
    dword(32'h0BAD_F00D);
    // rx_ready drop while in sync
    send(32'hB5B5_95BC, 4'b0001, 0, 0, 0, 0);
    repeat (3) idle();
    // random traffic with a mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      rand_word();
    end
    // saturation then clear with a same-cycle invalid word
    while (m_inv < MAXC) bad(0);
    bad(0); bad(0);
    bad(1);
    bad(0);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++)
      @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
